image_streamer: RTL and testbench
=================================

IMAGE_STREAMER -- requirements
Module: image_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter RESOLUTION, default 512, pixels per line and lines per frame (square frame).
REQ-003 SHALL derive local ADDR_W = $clog2(RESOLUTION*RESOLUTION) and CNT_W = $clog2(RESOLUTION).
REQ-004 SHALL have clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have arstn_i, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have start_i, input, 1, frame start request, sampled in IDLE only.
REQ-007 SHALL have busy_o, output, 1, high from the start acceptance until done.
REQ-008 SHALL have done_o, output, 1, one-cycle pulse after the last pixel handshake.
REQ-009 SHALL have mem_rd_o, output, 1, image memory read strobe.
REQ-010 SHALL have mem_addr_o, output, ADDR_W, raster address, line*RESOLUTION+column.
REQ-011 SHALL have mem_data_i, input, DATA_W, read data valid exactly one cycle after mem_rd_o.
REQ-012 SHALL have data_o, output, DATA_W, pixel to downstream line buffer.
REQ-013 SHALL have valid_o, output, 1, and ready_i, input, 1, the downstream handshake; a beat transfers when both are high.
REQ-014 SHALL have sol_o, eol_o, sof_o, eof_o, outputs, 1 each: column 0, column RESOLUTION-1, first pixel of frame, last pixel of frame, qualified by valid_o.

Function
REQ-015 SHALL implement FSM IDLE -> STREAM on start_i; STREAM -> DRAIN when the last address is issued; DRAIN -> IDLE when the last beat transfers, pulsing done_o in that transition's next cycle.
REQ-016 SHALL issue reads in raster order, column counter wrapping RESOLUTION-1 -> 0 and incrementing the line counter; line wrap RESOLUTION-1 ends issuing.
REQ-017 SHALL hold a 2-entry output FIFO; mem_rd_o asserts only when occupancy plus in-flight reads is less than 2, so no returned data is ever dropped.
REQ-018 SHALL, with ready_i held high, sustain one beat per cycle; first valid_o no later than 2 cycles after start_i acceptance.
REQ-019 SHALL keep data_o and the marker flags stable while valid_o is high and ready_i is low.
REQ-020 SHALL carry marker flags through the FIFO alongside each pixel.
REQ-021 SHALL ignore start_i outside IDLE.
REQ-022 SHALL transfer exactly RESOLUTION*RESOLUTION beats per frame.

Reset
REQ-023 SHALL, on arstn_i low, asynchronously force IDLE, counters and FIFO empty, and busy_o, done_o, mem_rd_o, valid_o, all flags low, mem_addr_o 0.
REQ-024 SHALL abandon a frame on reset mid-operation; any in-flight read data after release SHALL be discarded; next start_i begins at address 0.
REQ-025 SHALL leave data_o value unspecified while valid_o is low.

Configuration
REQ-026 SHALL, with macro IMAGE_STREAMER_LINE_GAP_EN defined, hold valid_o low for exactly one cycle after every eol_o beat transfer except the frame's last, and pause issuing reads correspondingly.
REQ-027 SHALL, without IMAGE_STREAMER_LINE_GAP_EN, stream lines back-to-back with no gap.

Verification (RESOLUTION=4, DATA_W=8, memory preloaded with value = address)
REQ-028 SHALL cover: start_i pulse, ready_i high -> 16 beats with data 0..15 on consecutive cycles, sof_o on beat 0, eol_o on beats 3,7,11,15, eof_o on beat 15, done_o once.
REQ-029 SHALL cover: ready_i low at beat 5 for 3 cycles -> data_o held at 5 with flags stable, no loss or duplicate, mem_rd_o low while FIFO is full.
REQ-030 SHALL cover: ready_i toggling every cycle -> 16 beats in order, busy_o high throughout.
REQ-031 SHALL cover: start_i asserted during STREAM -> ignored, exactly 16 beats.
REQ-032 SHALL cover: arstn_i low after beat 6 -> all outputs 0 immediately; new start_i yields data 0..15.
REQ-033 SHALL cover: with IMAGE_STREAMER_LINE_GAP_EN, ready_i high -> one idle cycle after beats 3, 7 and 11, total 19 cycles from first to last beat.

Source files
------------

// File: rtl/image_streamer.sv
// rtl/image_streamer.sv - raster-order image memory reader feeding a valid/ready pixel stream with frame/line markers.
// Optional IMAGE_STREAMER_LINE_GAP_EN inserts one idle output cycle after every line except the frame's last.
module image_streamer #(
    parameter  int DATA_W     = 8,
    parameter  int RESOLUTION = 512,
    localparam int ADDR_W     = $clog2(RESOLUTION*RESOLUTION),
    localparam int CNT_W      = $clog2(RESOLUTION)
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sol_o,
    output logic              eol_o,
    output logic              sof_o,
    output logic              eof_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RESOLUTION-1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_done_nxt;

    logic [CNT_W-1:0]  r_col;
    logic [CNT_W-1:0]  r_line;
    logic              r_inflight;
    logic [3:0]        r_pend_flags;
    logic              r_done;

    // Flag nibble layout everywhere: {sof, eof, sol, eol}
    logic [DATA_W-1:0] r_fifo_data  [2];
    logic [3:0]        r_fifo_flags [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;

    logic              w_col_first;
    logic              w_col_last;
    logic              w_line_first;
    logic              w_line_last;
    logic [3:0]        w_cur_flags;
    logic [3:0]        w_head_flags;
    logic              w_gap;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_room;
    logic              w_issue;
    logic              w_last_beat;

    assign w_col_first  = (r_col == '0);
    assign w_col_last   = (r_col == LAST_IDX);
    assign w_line_first = (r_line == '0);
    assign w_line_last  = (r_line == LAST_IDX);
    assign w_cur_flags  = {w_col_first && w_line_first, w_col_last && w_line_last,
                           w_col_first, w_col_last};

    assign w_head_flags = r_fifo_flags[r_rd_ptr];
    assign w_valid      = (r_count != 2'd0) && !w_gap;
    assign w_pop        = w_valid && ready_i;
    assign w_push       = r_inflight;
    assign w_last_beat  = w_pop && w_head_flags[2];

    // A slot freed by this cycle's pop counts as room, so ready-high streaming sustains one beat per cycle.
    assign w_room  = ({1'b0, r_count} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
    assign w_issue = (r_state == S_STREAM) && w_room;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_issue && w_col_last && w_line_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_beat) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_col        <= '0;
            r_line       <= '0;
            r_inflight   <= 1'b0;
            r_pend_flags <= 4'd0;
        end else begin
            r_inflight <= w_issue;
            if (r_state == S_IDLE) begin
                r_col  <= '0;
                r_line <= '0;
            end else if (w_issue) begin
                r_pend_flags <= w_cur_flags;
                if (w_col_last) begin
                    r_col  <= '0;
                    r_line <= w_line_last ? '0 : r_line + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Read data lands here one cycle after its strobe; the room check guarantees a free slot.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_flags[0] <= 4'd0;
            r_fifo_flags[1] <= 4'd0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr]  <= mem_data_i;
                r_fifo_flags[r_wr_ptr] <= r_pend_flags;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

`ifdef IMAGE_STREAMER_LINE_GAP_EN
    logic r_gap;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_gap <= 1'b0;
        end else begin
            r_gap <= w_pop && w_head_flags[0] && !w_head_flags[2];
        end
    end

    assign w_gap = r_gap;
`else
    assign w_gap = 1'b0;
`endif

    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = r_done;
    assign mem_rd_o   = w_issue;
    assign mem_addr_o = ADDR_W'(r_line) * ADDR_W'(RESOLUTION) + ADDR_W'(r_col);
    assign data_o     = r_fifo_data[r_rd_ptr];
    assign valid_o    = w_valid;
    assign sof_o      = w_valid && w_head_flags[3];
    assign eof_o      = w_valid && w_head_flags[2];
    assign sol_o      = w_valid && w_head_flags[1];
    assign eol_o      = w_valid && w_head_flags[0];

endmodule

// File: tb/tb_image_streamer.sv
// tb/tb_image_streamer.sv - directed self-checking bench for image_streamer at RESOLUTION=4, memory value = address.
module tb_image_streamer;

`ifdef IMAGE_STREAMER_LINE_GAP_EN
    localparam int SPAN = 18;
`else
    localparam int SPAN = 15;
`endif

    logic       clk = 1'b0;
    logic       arstn;
    logic       start;
    logic       busy;
    logic       done;
    logic       mem_rd;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       sol;
    logic       eol;
    logic       sof;
    logic       eof;

    image_streamer #(.DATA_W(8), .RESOLUTION(4)) dut (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .mem_rd_o   (mem_rd),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .sol_o      (sol),
        .eol_o      (eol),
        .sof_o      (sof),
        .eof_o      (eof)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) mem_data <= {4'd0, mem_addr};

    logic [7:0] cap_data  [$];
    logic [3:0] cap_flags [$];
    int         cap_cyc   [$];
    int         done_cnt = 0;
    int         done_cyc = 0;

    always @(negedge clk) begin
        if (valid && ready) begin
            cap_data.push_back(data);
            cap_flags.push_back({sof, eof, sol, eol});
            cap_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_flags.delete();
        cap_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(output int acc);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt > d0) break;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > d0), 1);
    endtask

    task automatic check_frame(input string tag);
        logic [11:0] exp;
        chk({tag, "_beats"}, cap_data.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < cap_data.size()) begin
                exp = {8'(i), i == 0, i == 15, (i % 4) == 0, (i % 4) == 3};
                chk($sformatf("%s_beat%0d", tag, i), {20'd0, cap_data[i], cap_flags[i]}, {20'd0, exp});
            end
        end
    endtask

    int acc;
    int busy_bad;

    initial begin
        arstn = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {24'd0, busy, done, mem_rd, valid, sol, eol, sof, eof}, 0);
        chk("reset_addr", mem_addr, 0);
        arstn = 1'b1;

        // Frame with ready held high
        ready = 1'b1;
        clear_cap();
        pulse_start(acc);
        wait_done("t1", 100);
        check_frame("t1");
        chk("t1_first_latency", 32'((cap_cyc[0] - acc) <= 2 && (cap_cyc[0] - acc) > 0), 1);
        chk("t1_span", cap_cyc[15] - cap_cyc[0], SPAN);
`ifdef IMAGE_STREAMER_LINE_GAP_EN
        chk("t1_gap_after_3", cap_cyc[4] - cap_cyc[3], 2);
        chk("t1_gap_after_11", cap_cyc[12] - cap_cyc[11], 2);
`endif
        chk("t1_done_after_last", done_cyc - cap_cyc[15], 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t1_done_once", done_cnt, 1);
        chk("t1_idle_busy", busy, 0);

        // Stall at beat 5 for three cycles
        clear_cap();
        ready = 1'b1;
        pulse_start(acc);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (valid && data == 8'd5) break;
        end
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t2_hold_valid%0d", k), valid, 1);
            chk($sformatf("t2_hold_data%0d", k), data, 5);
            chk($sformatf("t2_hold_flags%0d", k), {sof, eof, sol, eol}, 0);
            chk($sformatf("t2_no_read%0d", k), mem_rd, 0);
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        wait_done("t2", 100);
        check_frame("t2");

        // ready toggling every cycle
        clear_cap();
        ready = 1'b0;
        busy_bad = 0;
        pulse_start(acc);
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            if (!busy) busy_bad++;
            ready = ~ready;
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("t3_busy_held", busy_bad, 0);
        chk("t3_done_once", done_cnt, 1);
        check_frame("t3");

        // start_i during STREAM is ignored
        clear_cap();
        ready = 1'b1;
        pulse_start(acc);
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        wait_done("t4", 100);
        check_frame("t4");
        repeat (5) @(posedge clk);
        #1;
        chk("t4_no_restart", busy, 0);
        chk("t4_done_once", done_cnt, 1);

        // Reset after beat 6, then a clean frame
        clear_cap();
        ready = 1'b1;
        pulse_start(acc);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cap_data.size() >= 7) break;
        end
        chk("t5_beats_before_reset", cap_data.size(), 7);
        #2 arstn = 1'b0;
        #1;
        chk("t5_reset_ctrl", {24'd0, busy, done, mem_rd, valid, sol, eol, sof, eof}, 0);
        chk("t5_reset_addr", mem_addr, 0);
        chk("t5_reset_data", data, 0);
        @(posedge clk);
        #1 arstn = 1'b1;
        clear_cap();
        pulse_start(acc);
        wait_done("t5", 100);
        check_frame("t5");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
